// File: rtl/weight_seq.sv
// Coefficient sequencer: streams a MEM_SIZE-deep ROM REPEAT times into a FIFO via a 2-entry skid buffer.
// Define WEIGHT_SEQ_AUTOSTART_EN to run jobs back-to-back without ap_start.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

module weight_seq #(
  parameter int MEM_SIZE   = 64,
  parameter int DATA_WIDTH = `COEFF_WIDTH,
  parameter int REPEAT     = 1,
  localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
  localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [AW-1:0]         weight_V_address0,
  output logic                  weight_V_ce0,
  input  logic [DATA_WIDTH-1:0] weight_V_q0,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q;
  logic [PW-1:0]         pass_q;
  logic                  infl_q;
  logic [1:0]            occ_q, occ_nxt;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic                  pop, ce, last_addr, last_issue, go;
  logic [2:0]            level;

  assign pop        = (occ_q != 2'd0) && output_V_full_n;
  // Slots committed after this cycle's pop; issuing only below 2 means q0 always has a home.
  assign level      = 3'(occ_q) + 3'(infl_q) - 3'(pop);
  assign ce         = (state_q == RUN) && (level < 3'd2);
  assign occ_nxt    = occ_q + 2'(infl_q) - 2'(pop);
  assign last_addr  = (addr_q == AW'(MEM_SIZE - 1));
  assign last_issue = last_addr && (pass_q == PW'(REPEAT - 1));

`ifdef WEIGHT_SEQ_AUTOSTART_EN
  assign go = 1'b1;
`else
  assign go = ap_start;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (ce && last_issue) state_d = DRAIN;
      // Leave once the last word is leaving this cycle, so ap_done follows the final write directly.
      DRAIN:   if (occ_nxt == 2'd0) state_d = DONE;
      DONE: begin
`ifdef WEIGHT_SEQ_AUTOSTART_EN
        state_d = RUN;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      pass_q   <= '0;
      infl_q   <= 1'b0;
      occ_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= ce;
      occ_q   <= occ_nxt;
      if (state_q != RUN) begin
        addr_q <= '0;
        pass_q <= '0;
      end else if (ce) begin
        if (last_addr) begin
          addr_q <= '0;
          pass_q <= pass_q + PW'(1);
        end else begin
          addr_q <= addr_q + AW'(1);
        end
      end
      if (infl_q) begin
        buf_q[wr_ptr_q] <= weight_V_q0;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign ap_idle           = (state_q == IDLE);
  assign ap_done           = (state_q == DONE);
  assign weight_V_address0 = addr_q;
  assign weight_V_ce0      = ce;
  assign output_V_write    = pop;
  assign output_V_din      = buf_q[rd_ptr_q];

endmodule

// File: tb/tb_weight_seq.sv
// Directed bench for weight_seq: table of full_n patterns on a 4x2 job, plus reset and MEM_SIZE=1 sequences.
module tb_weight_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, start_b, fn_a, fn_b;
  logic       idle_a, done_a, ce_a, wr_a, idle_b, done_b, ce_b, wr_b;
  logic [1:0] addr_a;
  logic [0:0] addr_b;
  logic [7:0] q_a, q_b, din_a, din_b;

  int tests = 0;
  int fails = 0;

  logic [7:0] rom_a [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] rom_b     = 8'h5A;

  always @(posedge clk) if (ce_a) q_a <= rom_a[addr_a];
  always @(posedge clk) if (ce_b) q_b <= rom_b;

  weight_seq #(.MEM_SIZE(4), .DATA_WIDTH(8), .REPEAT(2)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_a), .ap_idle(idle_a), .ap_done(done_a),
    .weight_V_address0(addr_a), .weight_V_ce0(ce_a), .weight_V_q0(q_a),
    .output_V_din(din_a), .output_V_full_n(fn_a), .output_V_write(wr_a));

  weight_seq #(.MEM_SIZE(1), .DATA_WIDTH(8), .REPEAT(3)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_b), .ap_idle(idle_b), .ap_done(done_b),
    .weight_V_address0(addr_b), .weight_V_ce0(ce_b), .weight_V_q0(q_b),
    .output_V_din(din_b), .output_V_full_n(fn_b), .output_V_write(wr_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // k counts cycles from the one in which ap_start is sampled; full_n is held low for k=1..stall.
  task automatic run_a(input int stall, input logic [7:0] pat, input int exp_first,
                       input int exp_done, input string tag);
    int nw = 0, nce = 0, ndone = 0, first = -1, done_k = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start_a = (k == 0);
      fn_a    = (stall > 0 && k <= stall) ? 1'b0 : pat[k % 8];
      #1;
      if (wr_a) begin
        if (nw < 8) chk({tag, " data"}, din_a, rom_a[nw % 4]);
        if (first < 0) first = k;
        nw++;
      end
      if (ce_a) nce++;
      if (done_a) begin ndone++; done_k = k; end
      if (stall > 0 && (k == 5 || k == stall)) begin
        chk({tag, " stall din"}, din_a, 8'hA1);
        chk({tag, " stall writes"}, nw, 0);
      end
      if (stall > 0 && k == stall) chk({tag, " stall ce0 count"}, nce, 2);
    end
    chk({tag, " write count"}, nw, 8);
    chk({tag, " ce0 count"}, nce, 8);
    chk({tag, " done pulses"}, ndone, 1);
    chk({tag, " first write cycle"}, first, exp_first);
    chk({tag, " done cycle"}, done_k, exp_done);
    chk({tag, " idle after job"}, idle_a, 1'b1);
  endtask

  typedef struct {
    int         stall;
    logic [7:0] pat;
    int         first;
    int         done_k;
  } vec_t;

  vec_t vt [4];

  initial begin
    int nw, nce, ndone, done_k;
    vt[0] = '{stall: 0,  pat: 8'hFF, first: 3,  done_k: 11};
    vt[1] = '{stall: 0,  pat: 8'h55, first: 4,  done_k: 19};
    vt[2] = '{stall: 0,  pat: 8'hFE, first: 3,  done_k: 12};
    vt[3] = '{stall: 20, pat: 8'hFF, first: 21, done_k: 29};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; fn_a = 1'b1; fn_b = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset idle", idle_a, 1'b1);
    chk("reset done", done_a, 1'b0);
    chk("reset ce0", ce_a, 1'b0);
    chk("reset write", wr_a, 1'b0);
    chk("reset addr", addr_a, 2'd0);
    chk("reset din", din_a, 8'h00);
    chk("reset idle b", idle_b, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_a(vt[i].stall, vt[i].pat, vt[i].first, vt[i].done_k, $sformatf("vec%0d", i));

    // Reset while reading pass 1, address 2.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start_a = (k == 0);
      fn_a    = 1'b1;
      rst_n   = (k != 7);
      #1;
      if (k == 7) chk("pre-reset addr", addr_a, 2'd2);
      if (k == 8) begin
        chk("mid reset idle", idle_a, 1'b1);
        chk("mid reset write", wr_a, 1'b0);
        chk("mid reset ce0", ce_a, 1'b0);
        chk("mid reset addr", addr_a, 2'd0);
        chk("mid reset din", din_a, 8'h00);
      end
      if (k == 9) chk("post release write", wr_a, 1'b0);
    end
    run_a(0, 8'hFF, 3, 11, "after reset");

    // MEM_SIZE=1, REPEAT=3, with ap_start held through RUN/DRAIN.
    nw = 0; nce = 0; ndone = 0; done_k = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start_b = (k <= 4);
      fn_b    = 1'b1;
      #1;
      if (wr_b) begin
        chk("m1 data", din_b, 8'h5A);
        chk("m1 write cycle", k, 3 + nw);
        nw++;
      end
      if (ce_b) nce++;
      if (done_b) begin ndone++; done_k = k; end
    end
    chk("m1 write count", nw, 3);
    chk("m1 ce0 count", nce, 3);
    chk("m1 done pulses", ndone, 1);
    chk("m1 done cycle", done_k, 6);
    chk("m1 idle", idle_b, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
